// File: rtl/inverse_dither_filter_pkg.sv
// Shared constants and types for the inverse dither filter.
// Optional build macro used elsewhere: INVDITHER_DEGAMMA_EN.
package inverse_dither_filter_pkg;

  localparam int BPP_ONE          = 1;
  localparam int BPP_FOUR         = 4;
  localparam int LB_ABITS_DEFAULT = 12;

  // out = (total + KERNEL_ROUND) >> KERNEL_SHIFT; kernel weights sum to 8
  localparam int KERNEL_SHIFT = 3;
  localparam int KERNEL_ROUND = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_TAIL   = 2'd2
  } state_e;

endpackage

// File: rtl/bramdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module bramdp #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/inverse_dither_filter_expand.sv
// Maps a dithered Y4/Y1 pixel to 8-bit linear. With INVDITHER_DEGAMMA_EN
// defined, BPP=4 goes through the ditherer's degamma table instead.
module inverse_dither_expand
  import inverse_dither_filter_pkg::*;
#(
  parameter int BPP = BPP_FOUR
) (
  input  logic [3:0] in,
  output logic [7:0] e
);

  if (BPP == BPP_ONE) begin : g_bpp1
    logic unused_low_bits;
    assign unused_low_bits = ^in[2:0];
    assign e = in[3] ? 8'hFF : 8'h00;
  end else if (BPP == BPP_FOUR) begin : g_bpp4
`ifdef INVDITHER_DEGAMMA_EN
    degamma u_degamma (
      .in  ({in, in[3:2]}),
      .out (e)
    );
`else
    assign e = {in, in};
`endif
  end else begin : g_bad_bpp
    $error("inverse_dither_expand: BPP must be 1 or 4");
  end

endmodule

// File: rtl/inverse_dither_filter.sv
// Reconstructs Y8 from dithered Y4/Y1 with a [1 2 1] x 2-row low-pass.
// Build option: INVDITHER_DEGAMMA_EN selects degamma expansion for BPP=4.
module inverse_dither_filter
  import inverse_dither_filter_pkg::*;
#(
  parameter int BPP      = BPP_FOUR,
  parameter int LB_ABITS = LB_ABITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       in_valid,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [1:0] dbg_state
);

  // Handshake: out_valid is a one-cycle qualifier for out; there is no
  // back-pressure, pixel x appears exactly 3 cycles after it was accepted.

  state_e              state_q, state_d;
  logic [LB_ABITS-1:0] x_q, x_d;
  logic                first_line_q, first_line_d;
  logic                line_seen_q, line_seen_d;

  // Stage A: pixel x+1 (newest), stage B: pixel x (being filtered), stage C: x-1
  logic       a_v_q, a_v_d, a_first_q, a_first_d, a_fl_q, a_fl_d;
  logic [7:0] a_e_q, a_e_d;
  logic       b_v_q, b_v_d, b_first_q, b_first_d, b_fl_q, b_fl_d;
  logic [7:0] b_e_q, b_e_d, b_p_q, b_p_d;
  logic [7:0] c_e_q, c_e_d, c_p_q, c_p_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [7:0]  e, lb_rdata;
  logic [7:0]  left_e, right_e, left_p, right_p;
  logic [9:0]  row_cur, row_prev;
  logic [10:0] total, rounded;
  logic        has_right;

  inverse_dither_expand #(.BPP(BPP)) u_expand (
    .in (in),
    .e  (e)
  );

  bramdp #(.AW(LB_ABITS), .DW(8)) u_line_buf (
    .clk   (clk),
    .we    (in_valid),
    .waddr (x_q),
    .wdata (e),
    .raddr (x_q),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!in_valid) state_d = ST_TAIL;
      ST_TAIL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dbg_state = state_q;
  end

  // vsync has priority over hsync; first_line only clears after a non-empty line
  always_comb begin
    x_d          = x_q;
    first_line_d = first_line_q;
    line_seen_d  = line_seen_q;
    if (vsync) begin
      x_d          = '0;
      first_line_d = 1'b1;
      line_seen_d  = 1'b0;
    end else if (hsync) begin
      x_d         = '0;
      line_seen_d = 1'b0;
      if (line_seen_q) first_line_d = 1'b0;
    end else if (in_valid) begin
      x_d         = x_q + 1'b1;
      line_seen_d = 1'b1;
    end
  end

  always_comb begin
    a_v_d     = in_valid;
    a_e_d     = e;
    a_first_d = (x_q == '0);
    a_fl_d    = first_line_q;
    b_v_d     = a_v_q;
    b_e_d     = a_e_q;
    b_p_d     = lb_rdata;
    b_first_d = a_first_q;
    b_fl_d    = a_fl_q;
    c_e_d     = b_e_q;
    c_p_d     = b_p_q;
  end

  // lb_rdata is aligned with stage A: it is the previous-line value of pixel x+1
  always_comb begin
    has_right = a_v_q && !a_first_q;
    left_e    = b_first_q ? b_e_q : c_e_q;
    left_p    = b_first_q ? b_p_q : c_p_q;
    right_e   = has_right ? a_e_q : b_e_q;
    right_p   = has_right ? lb_rdata : b_p_q;
    row_cur   = {2'b00, left_e} + {1'b0, b_e_q, 1'b0} + {2'b00, right_e};
    row_prev  = {2'b00, left_p} + {1'b0, b_p_q, 1'b0} + {2'b00, right_p};
    total     = {1'b0, row_cur} + {1'b0, (b_fl_q ? row_cur : row_prev)};
    rounded   = total + 11'(KERNEL_ROUND);
    out_d       = b_v_q ? rounded[KERNEL_SHIFT +: 8] : out_q;
    out_valid_d = b_v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      first_line_q <= 1'b1;
      line_seen_q  <= 1'b0;
      a_v_q        <= 1'b0;
      b_v_q        <= 1'b0;
      out_q        <= 8'h00;
      out_valid_q  <= 1'b0;
    end else begin
      x_q          <= x_d;
      first_line_q <= first_line_d;
      line_seen_q  <= line_seen_d;
      a_v_q        <= a_v_d;
      b_v_q        <= b_v_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    a_e_q     <= a_e_d;
    a_first_q <= a_first_d;
    a_fl_q    <= a_fl_d;
    b_e_q     <= b_e_d;
    b_p_q     <= b_p_d;
    b_first_q <= b_first_d;
    b_fl_q    <= b_fl_d;
    c_e_q     <= c_e_d;
    c_p_q     <= c_p_d;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inverse_dither_filter.sv
// Scoreboard bench for inverse_dither_filter: one BPP=4 and one BPP=1 instance.
module tb_inverse_dither_filter;
  import inverse_dither_filter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in4, in1;
  logic       v4, v1, hsync, vsync;
  logic [7:0] out4, out1;
  logic       ov4, ov1;
  logic [1:0] st4, st1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // {expected cycle, expected pixel}
  logic [39:0] exp4_q[$];
  logic [39:0] exp1_q[$];

  logic [3:0] pix_a [0:15];
  logic [7:0] exp_a [0:15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inverse_dither_filter #(.BPP(4), .LB_ABITS(12)) u4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(v4), .hsync(hsync), .vsync(vsync),
    .out(out4), .out_valid(ov4), .dbg_state(st4)
  );

  inverse_dither_filter #(.BPP(1), .LB_ABITS(12)) u1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(v1), .hsync(hsync), .vsync(vsync),
    .out(out1), .out_valid(ov1), .dbg_state(st1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: every out_valid must match the oldest expected entry, in value and cycle
  always @(negedge clk) begin
    if (ov4) begin
      if (exp4_q.size() == 0) begin
        total++; bad++;
        $display("FAIL u4 extra output: got %0h want none (cycle %0d)", out4, cyc);
      end else begin
        logic [39:0] e;
        e = exp4_q.pop_front();
        check("u4 data", {24'h0, out4}, {24'h0, e[7:0]});
        check("u4 latency", cyc, e[39:8]);
      end
    end
  end

  always @(negedge clk) begin
    if (ov1) begin
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL u1 extra output: got %0h want none (cycle %0d)", out1, cyc);
      end else begin
        logic [39:0] e;
        e = exp1_q.pop_front();
        check("u1 data", {24'h0, out1}, {24'h0, e[7:0]});
        check("u1 latency", cyc, e[39:8]);
      end
    end
  end

  task automatic fill(input logic [3:0] p, input logic [7:0] x);
    for (int i = 0; i < 16; i++) begin
      pix_a[i] = p;
      exp_a[i] = x;
    end
  endtask

  task automatic drive_line(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 4) begin
        v4 = 1'b1; in4 = pix_a[i];
        exp4_q.push_back({32'(cyc + 3), exp_a[i]});
      end else begin
        v1 = 1'b1; in1 = pix_a[i];
        exp1_q.push_back({32'(cyc + 3), exp_a[i]});
      end
    end
    @(negedge clk);
    v4 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic pulse(input logic h, input logic v);
    @(negedge clk); hsync = h; vsync = v;
    @(negedge clk); hsync = 1'b0; vsync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; v4 = 1'b0; v1 = 1'b0; in4 = 4'h0; in1 = 4'h0;
    hsync = 1'b0; vsync = 1'b0;
    idle(3);
    check("reset out4", {24'h0, out4}, 32'h0);
    check("reset ov4", {31'h0, ov4}, 32'h0);
    check("reset st4", {30'h0, st4}, 32'(ST_IDLE));
    check("reset out1", {24'h0, out1}, 32'h0);
    check("reset ov1", {31'h0, ov1}, 32'h0);
    check("reset st1", {30'h0, st1}, 32'(ST_IDLE));
    rst = 1'b0;
    idle(2);

    // Flat 4'h8, 16x4: everything is 8'h88
    pulse(1'b0, 1'b1);
    fill(4'h8, 8'h88);
    for (int y = 0; y < 4; y++) begin
      drive_line(4, 16);
      pulse(1'b1, 1'b0);
    end
    idle(4);

    // BPP=1 checkerboard 8x4: first-line edges are 64/191, everything else 128
    pulse(1'b0, 1'b1);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        pix_a[x] = (((x + y) & 1) != 0) ? 4'hF : 4'h0;
        exp_a[x] = 8'd128;
      end
      if (y == 0) begin
        exp_a[0] = 8'd64;
        exp_a[7] = 8'd191;
      end
      drive_line(1, 8);
      pulse(1'b1, 1'b0);
    end
    idle(4);

    // Bright line then dark line, width 4
    pulse(1'b0, 1'b1);
    fill(4'hF, 8'hFF);
    drive_line(4, 4);
    pulse(1'b1, 1'b0);
    fill(4'h0, 8'd128);
    drive_line(4, 4);
    idle(4);

    // Stale 0xFF in the line buffer must be ignored on a new frame's first line
    pulse(1'b0, 1'b1);
    fill(4'hF, 8'hFF);
    drive_line(4, 4);
    pulse(1'b0, 1'b1);
    fill(4'h0, 8'h00);
    drive_line(4, 4);
    idle(4);

    // Single-pixel line, then walk the FSM back to IDLE
    pulse(1'b0, 1'b1);
    fill(4'h4, 8'h44);
    drive_line(4, 1);
    check("single st active", {30'h0, st4}, 32'(ST_ACTIVE));
    @(negedge clk);
    check("single st tail", {30'h0, st4}, 32'(ST_TAIL));
    @(negedge clk);
    check("single st idle", {30'h0, st4}, 32'(ST_IDLE));
    idle(4);

    // Reset on pixel 5 of a 10-pixel line: only pixels 0..2 have left the pipe
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v4 = 1'b1; in4 = 4'h3;
      if (i < 3) exp4_q.push_back({32'(cyc + 3), 8'h33});
      if (i == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;
    check("rst ov4", {31'h0, ov4}, 32'h0);
    check("rst out4", {24'h0, out4}, 32'h0);
    check("rst st4", {30'h0, st4}, 32'(ST_IDLE));
    idle(5);
    pulse(1'b1, 1'b0);
    fill(4'h6, 8'h66);
    drive_line(4, 4);

    for (int i = 0; i < 40 && (exp4_q.size() != 0 || exp1_q.size() != 0); i++) @(negedge clk);
    idle(3);
    check("u4 queue drained", exp4_q.size(), 32'h0);
    check("u1 queue drained", exp1_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
